// File: rtl/seq_mag_comp.sv
// -----------------------------------------------------------------------------
// seq_mag_comp
//   Sequential magnitude comparator. Two WIDTH-bit operands are captured on the
//   accepting edge. They are then compared CHUNK bits per clock, starting with
//   the most significant chunk. The compare stops at the first chunk that
//   differs, so a wide compare never sits in one long combinational path.
//   The SIGNED parameter selects two's-complement order instead of unsigned.
//
//   Result encoding on o: 2 = A>B, 1 = A==B, 0 = A<B.
//
// Parameters
//   WIDTH   operand width in bits; must be a multiple of CHUNK
//   CHUNK   bits compared per cycle, 1 <= CHUNK <= WIDTH
//   SIGNED  0 = unsigned compare, 1 = two's-complement compare
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      compare request, sampled only while busy=0
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   busy   out  1      compare in progress; start is ignored while high
//   done   out  1      one-cycle pulse; o is valid from this cycle on
//   o      out  2      result, held until the next done
// -----------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o
);

    localparam int              NCHUNK   = WIDTH / CHUNK;
    localparam int              IDXW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic            MSB_FLIP = (SIGNED != 0);

    localparam logic [1:0] RES_LT = 2'd0;
    localparam logic [1:0] RES_EQ = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             busy_q;
    logic             done_q;
    logic [1:0]       o_q;

    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] ra_d;
    logic [WIDTH-1:0] rb_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [1:0]       o_d;
    logic             resolve;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && start;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the chunk datapath is identical in both modes.
    always_comb begin
        ra_d            = a;
        rb_d            = b;
        ra_d[WIDTH-1]   = a[WIDTH-1] ^ MSB_FLIP;
        rb_d[WIDTH-1]   = b[WIDTH-1] ^ MSB_FLIP;
    end

    // Operand copies carry no reset: they are only read in CMP, which is always
    // entered through a capture.
    always_ff @(posedge clk) begin
        if (accept) begin
            ra_q <= ra_d;
            rb_q <= rb_d;
        end
    end

    // Current chunk pair and the verdict it would give if it resolves now.
    always_comb begin
        chunk_a = ra_q[idx_q*CHUNK +: CHUNK];
        chunk_b = rb_q[idx_q*CHUNK +: CHUNK];
        resolve = (chunk_a != chunk_b) || (idx_q == '0);
        if (chunk_a > chunk_b) begin
            o_d = RES_GT;
        end else if (chunk_a < chunk_b) begin
            o_d = RES_LT;
        end else begin
            o_d = RES_EQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= RES_LT;
        end else begin
            // done is a single-cycle pulse; only the resolving edge sets it.
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q   <= LAST_IDX;
                        busy_q  <= 1'b1;
                        state_q <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (resolve) begin
                        o_q     <= o_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
// -----------------------------------------------------------------------------
// tb_seq_mag_comp
//   Six comparator instances (CHUNK 4/1/16, SIGNED 0/1) share one stimulus.
//   A behavioural model predicts busy/done/o for each instance from the
//   full-width compare and the first-differing-chunk latency; it is checked on
//   every clock. Directed tests add literal expectations on instance 0/1.
// -----------------------------------------------------------------------------
module tb_seq_mag_comp;

    localparam int NI = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   a_in = '0;
    logic [15:0]   b_in = '0;
    logic [NI-1:0] busy_w;
    logic [NI-1:0] done_w;
    logic [1:0]    o_w [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int ch_of(int i);
        case (i)
            0, 1:    return 4;
            2, 3:    return 1;
            default: return 16;
        endcase
    endfunction

    function automatic int sg_of(int i);
        return i % 2;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            seq_mag_comp #(
                .WIDTH  (16),
                .CHUNK  (ch_of(gi)),
                .SIGNED (sg_of(gi))
            ) u_dut (
                .clk   (clk),
                .rst_n (rst_n),
                .start (start),
                .a     (a_in),
                .b     (b_in),
                .busy  (busy_w[gi]),
                .done  (done_w[gi]),
                .o     (o_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string name, input int inst, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s inst=%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
        end
    endtask

    // Reference: full-width compare for the result, prefix compare for latency.
    function automatic void model_eval(input int i, input logic [15:0] x, input logic [15:0] y,
                                       output int res, output int k);
        int ch = ch_of(i);
        int n  = 16 / ch;
        if (sg_of(i) != 0)
            res = ($signed(x) > $signed(y)) ? 2 : (($signed(x) == $signed(y)) ? 1 : 0);
        else
            res = (x > y) ? 2 : ((x == y) ? 1 : 0);
        k = n;
        for (int j = 1; j <= n; j++) begin
            if ((x >> (16 - j*ch)) != (y >> (16 - j*ch))) begin
                k = j;
                break;
            end
        end
    endfunction

    // Model state per instance
    bit m_busy [NI];
    bit m_done [NI];
    int m_o    [NI];
    int m_res  [NI];
    int m_left [NI];

    // Per-cycle model step and compare, 1 time unit after each rising edge.
    initial begin
        logic        s_rst, s_start;
        logic [15:0] s_a, s_b;
        int          r, k;
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 0; m_done[i] = 0; m_o[i] = 0; m_res[i] = 0; m_left[i] = 0;
        end
        forever begin
            @(posedge clk);
            s_rst = rst_n; s_start = start; s_a = a_in; s_b = b_in;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (!s_rst || !rst_n) begin
                    m_busy[i] = 0; m_done[i] = 0; m_o[i] = 0;
                end else begin
                    m_done[i] = 0;
                    if (m_busy[i]) begin
                        m_left[i]--;
                        if (m_left[i] == 0) begin
                            m_busy[i] = 0; m_done[i] = 1; m_o[i] = m_res[i];
                        end
                    end else if (s_start) begin
                        model_eval(i, s_a, s_b, r, k);
                        m_res[i] = r; m_left[i] = k; m_busy[i] = 1;
                    end
                end
                chk("cyc_busy", i, int'(busy_w[i]), int'(m_busy[i]));
                chk("cyc_done", i, int'(done_w[i]), int'(m_done[i]));
                chk("cyc_o",    i, int'(o_w[i]),    m_o[i]);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy_w != '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", -1, int'(busy_w), 0);
        @(negedge clk);
    endtask

    // One compare with literal latency/result on inst 0 and result on inst 1.
    task automatic run_one(input string name, input logic [15:0] x, input logic [15:0] y,
                           input int ek, input int eo0, input int eo1);
        int n = 0;
        int got_o = -1;
        bit got = 0;
        @(negedge clk);
        start = 1'b1; a_in = x; b_in = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; a_in = 16'($urandom); b_in = 16'($urandom);
        while (!got && n < 40) begin
            @(posedge clk);
            #2;
            n++;
            if (done_w[0]) begin
                got = 1;
                got_o = int'(o_w[0]);
            end
        end
        chk({name, "_k"}, 0, n, ek);
        chk({name, "_o"}, 0, got_o, eo0);
        wait_idle();
        chk({name, "_o_signed"}, 1, int'(o_w[1]), eo1);
        $display("[TB] %s a=%h b=%h k=%0d o=%0d o_signed=%0d", name, x, y, n, got_o, o_w[1]);
    endtask

    initial begin
        int dcount, dedge, dout;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk("reset_busy", i, int'(busy_w[i]), 0);
            chk("reset_done", i, int'(done_w[i]), 0);
            chk("reset_o",    i, int'(o_w[i]),    0);
        end
        $display("[TB] reset checked");
        rst_n = 1'b1;
        @(negedge clk);

        // Equal, early exit, last-chunk difference
        run_one("equal",    16'h1234, 16'h1234, 4, 1, 1);
        run_one("early",    16'h8000, 16'h7FFF, 1, 2, 0);
        run_one("last_lt",  16'h1230, 16'h1231, 4, 0, 0);
        run_one("last_gt",  16'hFFFF, 16'hFFFE, 4, 2, 2);

        // Start while busy: second pulse on edge 2 is ignored by instance 0
        @(negedge clk);
        start = 1'b1; a_in = 16'h0001; b_in = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; a_in = 16'hF000; b_in = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dcount = 0; dedge = -1; dout = -1;
        for (int n = 3; n <= 12; n++) begin
            @(posedge clk);
            #2;
            if (done_w[0]) begin
                dcount++; dedge = n; dout = int'(o_w[0]);
            end
        end
        chk("busy_start_dones", 0, dcount, 1);
        chk("busy_start_edge",  0, dedge, 4);
        chk("busy_start_o",     0, dout, 2);
        chk("busy_start_idle",  0, int'(busy_w[0]), 0);
        $display("[TB] start_while_busy dones=%0d edge=%0d o=%0d", dcount, dedge, dout);
        wait_idle();

        // Back-to-back: new start in the done cycle of an equal compare
        @(negedge clk);
        start = 1'b1; a_in = 16'h1234; b_in = 16'h1234;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        while (!done_w[0] && dcount < 40) begin
            @(posedge clk);
            #2;
            dcount++;
        end
        chk("b2b_first_k", 0, dcount, 4);
        @(negedge clk);
        start = 1'b1; a_in = 16'h0000; b_in = 16'h1000;
        @(posedge clk);
        #2;
        chk("b2b_accept_busy", 0, int'(busy_w[0]), 1);
        chk("b2b_hold_o",      0, int'(o_w[0]), 1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        chk("b2b_done", 0, int'(done_w[0]), 1);
        chk("b2b_o",    0, int'(o_w[0]), 0);
        $display("[TB] back_to_back done=%0d o=%0d", done_w[0], o_w[0]);
        wait_idle();

        // Reset mid-compare
        @(negedge clk);
        start = 1'b1; a_in = 16'h1234; b_in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", 0, int'(busy_w[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 0, int'(busy_w[0]), 0);
        chk("midrst_done", 0, int'(done_w[0]), 0);
        chk("midrst_o",    0, int'(o_w[0]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #2;
            if (done_w[0]) dcount++;
        end
        chk("midrst_no_done", 0, dcount, 0);
        $display("[TB] reset_mid_compare spurious_dones=%0d", dcount);
        run_one("after_rst", 16'h1234, 16'h1234, 4, 1, 1);

        // Random sweep with biased operand patterns; the model checks every cycle
        for (int t = 0; t < 1200; t++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       y = 16'($urandom);
                1:       y = x;
                2:       y = x ^ (16'h0001 << $urandom_range(0, 15));
                default: y = x ^ 16'($urandom_range(0, 15));
            endcase
            @(negedge clk);
            start = 1'b1; a_in = x; b_in = y;
            @(negedge clk);
            start = 1'b0;
            wait_idle();
            if (t % 200 == 0)
                $display("[TB] sweep %0d a=%h b=%h o=%0d", t, x, y, o_w[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
